// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared constants, word types and sizing helper for the register bank
package reg_bank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Register count for a given address width
  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_bank_scoreboard.sv
// rtl/reg_bank_scoreboard.sv - per-register pending bits with stall outputs (option: REG_BANK_BYPASS_EN)
module reg_bank_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wa3,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_wa,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);

  localparam int NREGS = nregs(ADDR_W);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             set_en;

  // Register 0 never becomes pending when it is hardwired to zero
  assign set_en = busy_set && ((ZERO_REG == 0) || (busy_wa != '0));

  // Retiring write clears its bit; a new issue to the same register wins
  always_comb begin
    pend_nxt = pend;
    if (wr_en) pend_nxt[wa3] = 1'b0;
    if (set_en) pend_nxt[busy_wa] = 1'b1;
  end

  // Pending-bit state with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  // Port status; a forwarded port is not stalled unless a new op reissues it
  always_comb begin
`ifdef REG_BANK_BYPASS_EN
    busy1 = pend[ra1] & ~(wr_en & (ra1 == wa3) & ~(set_en & (busy_wa == ra1)));
    busy2 = pend[ra2] & ~(wr_en & (ra2 == wa3) & ~(set_en & (busy_wa == ra2)));
`else
    busy1 = pend[ra1];
    busy2 = pend[ra2];
`endif
    stall = busy1 | busy2;
  end

endmodule

// File: rtl/reg_bank_param.sv
// rtl/reg_bank_param.sv - parametrised register bank, one write and two read ports, pending scoreboard (option: REG_BANK_BYPASS_EN)
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_wa,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);

  localparam int NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;

  // Writes to register 0 are dropped when it is hardwired to zero
  assign wr_en = we3 && ((ZERO_REG == 0) || (wa3 != '0));

  // Storage array with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa3] <= wd3;
    end
  end

  // Asynchronous read muxes, register 0 masked, optional write-through
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (ra1 == wa3)) rd1 = wd3;
    if (wr_en && (ra2 == wa3)) rd2 = wd3;
`endif
  end

  reg_bank_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wa3      (wa3),
    .busy_set (busy_set),
    .busy_wa  (busy_wa),
    .ra1      (ra1),
    .ra2      (ra2),
    .busy1    (busy1),
    .busy2    (busy2),
    .stall    (stall)
  );

endmodule

// File: tb/tb_reg_bank_param.sv
// tb/tb_reg_bank_param.sv - randomized and directed checks of reg_bank_param against a behavioural model
module tb_reg_bank_param;

  logic       clk;
  logic       rst;
  logic       we3;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic       busy_set;
  logic [2:0] busy_wa;
  logic       busy1;
  logic       busy2;
  logic       stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_regs [8];
  bit         m_busy [8];

  reg_bank_param dut (
    .clk      (clk),
    .rst      (rst),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .busy_set (busy_set),
    .busy_wa  (busy_wa),
    .busy1    (busy1),
    .busy2    (busy2),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit bypass_on();
`ifdef REG_BANK_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // A write lands only when enabled and not aimed at the hardwired zero register
  function automatic bit write_lands();
    return (we3 === 1'b1) && (wa3 != 3'd0);
  endfunction

  function automatic logic [7:0] model_rd(input logic [2:0] ra);
    if (bypass_on() && write_lands() && ra == wa3) return wd3;
    if (ra == 3'd0) return 8'h00;
    return m_regs[ra];
  endfunction

  function automatic bit model_busy(input logic [2:0] ra);
    bit reissued;
    reissued = busy_set && (busy_wa == ra) && (ra != 3'd0);
    if (bypass_on() && write_lands() && ra == wa3 && !reissued) return 1'b0;
    return m_busy[ra];
  endfunction

  task automatic drive(input bit r, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a1, input logic [2:0] a2, input bit bs, input logic [2:0] bwa);
    rst = r; we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2; busy_set = bs; busy_wa = bwa;
  endtask

  // Mid-cycle: compare all combinational outputs against the model
  task automatic settle();
    bit b1, b2;
    @(negedge clk);
    b1 = model_busy(ra1);
    b2 = model_busy(ra2);
    check("rd1", rd1, model_rd(ra1));
    check("rd2", rd2, model_rd(ra2));
    check("busy1", busy1, b1);
    check("busy2", busy2, b2);
    check("stall", stall, b1 | b2);
  endtask

  // Clock edge: apply reset, write and scoreboard rules to the model
  task automatic commit();
    bit wl;
    @(posedge clk);
    wl = write_lands();
    for (int a = 0; a < 8; a++) begin
      if (rst) begin
        m_regs[a] = 8'h00;
        m_busy[a] = 1'b0;
      end else begin
        if (wl && wa3 == a) m_regs[a] = wd3;
        if (busy_set && busy_wa == a && a != 0) m_busy[a] = 1'b1;
        else if (wl && wa3 == a) m_busy[a] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cyc(input bit r, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic [2:0] a1, input logic [2:0] a2, input bit bs, input logic [2:0] bwa);
    drive(r, we, wa, wd, a1, a2, bs, bwa);
    settle();
    commit();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) begin
      m_regs[a] = 8'hxx;
      m_busy[a] = 1'bx;
    end
    commit();

    // Reset clears a written register
    cyc(0, 1, 3, 8'hA5, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 0, 0, 0);
    settle();
    check("reset_rd1", rd1, 8'h00);
    check("reset_stall", stall, 1'b0);
    commit();

    // Hardwired zero register
    cyc(0, 1, 0, 8'hFF, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    check("zero_rd1", rd1, 8'h00);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("zero_busy1", busy1, 1'b0);
    commit();

    // Dual read, including both ports on one address
    cyc(0, 1, 2, 8'h11, 0, 0, 0, 0);
    cyc(0, 1, 5, 8'h22, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 5, 0, 0);
    settle();
    check("dual_rd1", rd1, 8'h11);
    check("dual_rd2", rd2, 8'h22);
    commit();
    drive(0, 0, 0, 0, 5, 5, 0, 0);
    settle();
    check("same_rd1", rd1, 8'h22);
    check("same_rd2", rd2, 8'h22);
    commit();

    // Scoreboard set, clear by write, set wins over clear
    cyc(0, 0, 0, 0, 0, 0, 1, 4);
    drive(0, 0, 0, 0, 4, 0, 0, 0);
    settle();
    check("sb_busy1", busy1, 1'b1);
    check("sb_stall", stall, 1'b1);
    commit();
    cyc(0, 1, 4, 8'h3C, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 4, 0, 0, 0);
    settle();
    check("sb_clr_busy1", busy1, 1'b0);
    check("sb_clr_rd1", rd1, 8'h3C);
    commit();
    cyc(0, 1, 4, 8'h5A, 4, 0, 1, 4);
    drive(0, 0, 0, 0, 4, 0, 0, 0);
    settle();
    check("sb_setwin_busy1", busy1, 1'b1);
    commit();

    // Same-cycle visibility of a write
    drive(0, 1, 6, 8'h77, 6, 0, 0, 0);
    settle();
    check("byp_rd1_now", rd1, bypass_on() ? 8'h77 : 8'h00);
    commit();
    drive(0, 0, 0, 0, 6, 0, 0, 0);
    settle();
    check("byp_rd1_next", rd1, 8'h77);
    commit();

    // Reset overrides write and busy_set
    cyc(1, 1, 1, 8'h99, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    settle();
    check("rstpri_rd1", rd1, 8'h00);
    check("rstpri_busy1", busy1, 1'b0);
    commit();

    // Randomized traffic; read addresses often track the write address
    for (int i = 0; i < 400; i++) begin
      logic [2:0] wa, a1, a2, bwa;
      wa  = 3'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      bwa = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), wa, 8'($urandom),
          a1, a2, ($urandom_range(0, 2) == 0), bwa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
